wave_sequencer: RTL and testbench

Parametrised playback controller for the wave generator: holds a queue of up to DEPTH waveform segments (per-channel amplitude, offset, phase word, plus a duration) and plays them back-to-back with no gap cycles. It sits in the `clk1` domain between the host-side parameter loaders and the synthesis bank. It drives that bank's parameter vectors and reset pulse, and it gates the output FIFO write enable.

---
 rtl/wave_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// wave_sequencer: queued waveform-segment playback controller driving the synthesis bank.
// Optional feature macro SEQ_LOOP_EN adds the loop port (popped segments recirculate to the tail).
module wave_sequencer #(
    parameter int NCH   = 64,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [1:0]               wr_sel,
    input  logic [$clog2(NCH)-1:0]   wr_ch,
    input  logic [DW-1:0]            wr_data,
    input  logic                     commit,
    input  logic                     start,
    input  logic                     stop,
`ifdef SEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic [NCH*DW-1:0]        amps,
    output logic [NCH*DW-1:0]        offsets,
    output logic [NCH*DW-1:0]        phasewords,
    output logic                     synth_reset,
    output logic                     sample_valid,
    output logic [DW-1:0]            count,
    output logic                     seg_done,
    output logic                     seq_done,
    output logic                     commit_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_reg, state_next;

    logic [DW-1:0] stg_amp [NCH];
    logic [DW-1:0] stg_off [NCH];
    logic [DW-1:0] stg_ph  [NCH];
    logic [DW-1:0] stg_dur;

    logic [DW-1:0] q_amp [DEPTH][NCH];
    logic [DW-1:0] q_off [DEPTH][NCH];
    logic [DW-1:0] q_ph  [DEPTH][NCH];
    logic [DW-1:0] q_dur [DEPTH];

    logic [DW-1:0] act_amp [NCH];
    logic [DW-1:0] act_off [NCH];
    logic [DW-1:0] act_ph  [NCH];

    logic [AW-1:0] head_reg, tail_reg, tail_inc, widx;
    logic [LW-1:0] level_reg, level_next;
    logic [DW-1:0] count_reg, count_next;
    logic          synth_reset_reg, sample_valid_reg, seg_done_reg, seq_done_reg;
    logic          commit_err_reg, full_reg, empty_reg;
    logic          pop, recirc, push, loop_on, queue_empty, queue_full;
    logic          seg_done_next, seq_done_next;

`ifdef SEQ_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        pop         = 1'b0;
        queue_empty = (level_reg == '0);
        queue_full  = (level_reg == LW'(DEPTH));
        case (state_reg)
            IDLE: begin
                if (start && !queue_empty) begin
                    pop        = 1'b1;
                    count_next = q_dur[head_reg];
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count_reg == '0) begin
                    // Gapless reload when another segment is waiting.
                    if (!queue_empty) begin
                        pop        = 1'b1;
                        count_next = q_dur[head_reg];
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            count_next = '0;
            pop        = 1'b0;
        end
        recirc = pop && loop_on;
        // A looping pop frees no slot, so only a plain pop lets a commit through when full.
        push          = commit && (!queue_full || (pop && !loop_on));
        tail_inc      = tail_reg + 1'b1;
        widx          = recirc ? tail_inc : tail_reg;
        level_next    = level_reg + LW'(push) + LW'(recirc) - LW'(pop);
        seg_done_next = (state_next == RUN) && (count_next == '0);
        seq_done_next = seg_done_next && (level_next == '0);
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            level_reg        <= '0;
            synth_reset_reg  <= 1'b0;
            sample_valid_reg <= 1'b0;
            seg_done_reg     <= 1'b0;
            seq_done_reg     <= 1'b0;
            commit_err_reg   <= 1'b0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            stg_amp          <= '{default: '0};
            stg_off          <= '{default: '0};
            stg_ph           <= '{default: '0};
            stg_dur          <= '0;
            act_amp          <= '{default: '0};
            act_off          <= '{default: '0};
            act_ph           <= '{default: '0};
            for (int d = 0; d < DEPTH; d++) begin
                q_amp[d] <= '{default: '0};
                q_off[d] <= '{default: '0};
                q_ph[d]  <= '{default: '0};
                q_dur[d] <= '0;
            end
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            head_reg         <= head_reg + AW'(pop);
            tail_reg         <= tail_reg + AW'(push) + AW'(recirc);
            level_reg        <= level_next;
            synth_reset_reg  <= pop;
            sample_valid_reg <= (state_next == RUN);
            seg_done_reg     <= seg_done_next;
            seq_done_reg     <= seq_done_next;
            commit_err_reg   <= commit && !push;
            full_reg         <= (level_next == LW'(DEPTH));
            empty_reg        <= (level_next == '0);
            if (wr_en) begin
                case (wr_sel)
                    2'd0:    stg_amp[wr_ch] <= wr_data;
                    2'd1:    stg_off[wr_ch] <= wr_data;
                    2'd2:    stg_ph[wr_ch]  <= wr_data;
                    default: stg_dur        <= wr_data;
                endcase
            end
            if (recirc) begin
                q_amp[tail_reg] <= q_amp[head_reg];
                q_off[tail_reg] <= q_off[head_reg];
                q_ph[tail_reg]  <= q_ph[head_reg];
                q_dur[tail_reg] <= q_dur[head_reg];
            end
            // Staging reads here see pre-write content when wr_en coincides with commit.
            if (push) begin
                q_amp[widx] <= stg_amp;
                q_off[widx] <= stg_off;
                q_ph[widx]  <= stg_ph;
                q_dur[widx] <= stg_dur;
            end
            if (pop) begin
                act_amp <= q_amp[head_reg];
                act_off <= q_off[head_reg];
                act_ph  <= q_ph[head_reg];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_pack
            assign amps[gi*DW +: DW]       = act_amp[gi];
            assign offsets[gi*DW +: DW]    = act_off[gi];
            assign phasewords[gi*DW +: DW] = act_ph[gi];
        end
    endgenerate

    assign synth_reset  = synth_reset_reg;
    assign sample_valid = sample_valid_reg;
    assign count        = count_reg;
    assign seg_done     = seg_done_reg;
    assign seq_done     = seq_done_reg;
    assign commit_err   = commit_err_reg;
    assign level        = level_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed self-checking bench for wave_sequencer (default parameters; loop test when SEQ_LOOP_EN is defined).
module tb_wave_sequencer;

    localparam int NCH   = 64;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic              clk1 = 1'b0;
    logic              reset, wr_en, commit, start, stop;
    logic [1:0]        wr_sel;
    logic [5:0]        wr_ch;
    logic [DW-1:0]     wr_data;
`ifdef SEQ_LOOP_EN
    logic              loop;
`endif
    logic [NCH*DW-1:0] amps, offsets, phasewords;
    logic              synth_reset, sample_valid, seg_done, seq_done, commit_err, full, empty;
    logic [DW-1:0]     count;
    logic [2:0]        level;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] E2_AMP [5] = '{16'hB001, 16'hB001, 16'hC002, 16'hC002, 16'hC002};
    localparam logic [15:0] E2_CNT [5] = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0};
    localparam logic        E2_SR  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic        E2_SEG [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic        E2_SEQ [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    wave_sequencer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk1(clk1), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch),
        .wr_data(wr_data), .commit(commit), .start(start), .stop(stop),
`ifdef SEQ_LOOP_EN
        .loop(loop),
`endif
        .amps(amps), .offsets(offsets), .phasewords(phasewords),
        .synth_reset(synth_reset), .sample_valid(sample_valid), .count(count),
        .seg_done(seg_done), .seq_done(seq_done), .commit_err(commit_err),
        .level(level), .full(full), .empty(empty)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic put(input logic [1:0] sel, input logic [5:0] ch, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_ch = ch; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic push_seg(input logic [15:0] amp, input logic [15:0] dur);
        put(2'd0, 6'd0, amp);
        put(2'd3, 6'd0, dur);
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0; start = 1'b0; stop = 1'b0;
        wr_sel = '0; wr_ch = '0; wr_data = '0;
`ifdef SEQ_LOOP_EN
        loop = 1'b0;
`endif
        // Reset state and start on an empty queue
        do_reset();
        check("rst_amp", amps[15:0], 0);
        check("rst_count", count, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_flags", {synth_reset, seg_done, seq_done, commit_err}, 0);
        start = 1'b1; step(); start = 1'b0;
        check("start_empty_valid", sample_valid, 0);
        $display("txn reset/empty-start done");

        // Single segment, duration 3
        put(2'd1, 6'd1, 16'h2222);
        put(2'd2, 6'd2, 16'h3333);
        push_seg(16'h1111, 16'd3);
        check("t1_level", level, 1);
        check("t1_empty", empty, 0);
        start = 1'b1; step(); start = 1'b0;
        check("t1_valid0", sample_valid, 1);
        check("t1_sr0", synth_reset, 1);
        check("t1_cnt0", count, 3);
        check("t1_amp", amps[15:0], 16'h1111);
        check("t1_off", offsets[31:16], 16'h2222);
        check("t1_ph", phasewords[47:32], 16'h3333);
        check("t1_seg0", seg_done, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t1_valid", sample_valid, 1);
            check("t1_cnt", count, 32'(3 - i));
            check("t1_sr", synth_reset, 0);
            check("t1_seg", seg_done, (i == 3) ? 1 : 0);
            check("t1_seq", seq_done, (i == 3) ? 1 : 0);
        end
        step();
        check("t1_valid_end", sample_valid, 0);
        check("t1_seg_end", seg_done, 0);
        check("t1_empty_end", empty, 1);
        $display("txn single segment done");

        // Two segments back to back (durations 1 and 2)
        push_seg(16'hB001, 16'd1);
        push_seg(16'hC002, 16'd2);
        check("t2_level", level, 2);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", sample_valid, 1);
            check("t2_amp", amps[15:0], E2_AMP[i]);
            check("t2_cnt", count, E2_CNT[i]);
            check("t2_sr", synth_reset, E2_SR[i]);
            check("t2_seg", seg_done, E2_SEG[i]);
            check("t2_seq", seq_done, E2_SEQ[i]);
            if (i == 2) check("t2_off_kept", offsets[31:16], 16'h2222);
            step();
        end
        check("t2_valid_end", sample_valid, 0);
        $display("txn two segments done");

        // Full queue: reject, then commit on a reload cycle
        do_reset();
        push_seg(16'hD000, 16'd1);
        push_seg(16'hD001, 16'd0);
        push_seg(16'hD002, 16'd0);
        push_seg(16'hD003, 16'd0);
        check("t3_level4", level, 4);
        check("t3_full", full, 1);
        commit = 1'b1; step(); commit = 1'b0;
        check("t3_err", commit_err, 1);
        check("t3_level_rej", level, 4);
        step();
        check("t3_err_clr", commit_err, 0);
        start = 1'b1; step(); start = 1'b0;
        check("t3_amp0", amps[15:0], 16'hD000);
        check("t3_level3", level, 3);
        check("t3_full_clr", full, 0);
        commit = 1'b1; step();
        check("t3_refill", level, 4);
        check("t3_cnt0", count, 0);
        check("t3_seg", seg_done, 1);
        step(); commit = 1'b0;
        check("t3_reload_level", level, 4);
        check("t3_reload_err", commit_err, 0);
        check("t3_reload_amp", amps[15:0], 16'hD001);
        check("t3_reload_sr", synth_reset, 1);
        stop = 1'b1; step(); stop = 1'b0;
        check("t3_stop_valid", sample_valid, 0);
        check("t3_stop_level", level, 4);
        $display("txn full queue done");

        // Stop mid-segment at count 5, then resume with the next segment
        do_reset();
        push_seg(16'hE000, 16'd7);
        push_seg(16'hF000, 16'd2);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("t4_cnt5", count, 5);
        stop = 1'b1; step(); stop = 1'b0;
        check("t4_valid", sample_valid, 0);
        check("t4_cnt", count, 0);
        check("t4_done", {seg_done, seq_done}, 0);
        check("t4_level", level, 1);
        check("t4_amp_kept", amps[15:0], 16'hE000);
        step();
        check("t4_idle_valid", sample_valid, 0);
        check("t4_idle_seg", seg_done, 0);
        start = 1'b1; step(); start = 1'b0;
        check("t4_amp_f", amps[15:0], 16'hF000);
        check("t4_cnt_f", count, 2);
        check("t4_sr_f", synth_reset, 1);
        check("t4_level_f", level, 0);
        step(); step();
        check("t4_seg_f", seg_done, 1);
        check("t4_seq_f", seq_done, 1);
        step();
        check("t4_valid_end", sample_valid, 0);
        $display("txn stop/resume done");

        // Two duration-0 segments; second commit coincides with a staging write
        do_reset();
        put(2'd0, 6'd0, 16'hA5A5);
        put(2'd3, 6'd0, 16'd0);
        wr_en = 1'b1; wr_sel = 2'd0; wr_ch = 6'd0; wr_data = 16'h5A5A; commit = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        commit = 1'b0;
        check("t5_level", level, 2);
        start = 1'b1; step(); start = 1'b0;
        check("t5_amp_g", amps[15:0], 16'hA5A5);
        check("t5_cnt_g", count, 0);
        check("t5_seg_g", seg_done, 1);
        check("t5_seq_g", seq_done, 0);
        check("t5_sr_g", synth_reset, 1);
        step();
        check("t5_amp_h", amps[15:0], 16'h5A5A);
        check("t5_valid_h", sample_valid, 1);
        check("t5_seg_h", seg_done, 1);
        check("t5_seq_h", seq_done, 1);
        check("t5_sr_h", synth_reset, 1);
        step();
        check("t5_valid_end", sample_valid, 0);
        check("t5_seg_end", seg_done, 0);
        $display("txn zero-duration pair done");

`ifdef SEQ_LOOP_EN
        // Looping playback: A, B, B repeating until stop
        do_reset();
        loop = 1'b1;
        push_seg(16'hAAAA, 16'd0);
        push_seg(16'hBBBB, 16'd1);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("t6_amp", amps[15:0], (i % 3 == 0) ? 16'hAAAA : 16'hBBBB);
            check("t6_seq", seq_done, 0);
            check("t6_level", level, 2);
            check("t6_valid", sample_valid, 1);
            step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        check("t6_stop_valid", sample_valid, 0);
        check("t6_stop_seq", seq_done, 0);
        loop = 1'b0;
        $display("txn loop playback done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
